// File: rtl/tile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tile_pkg
// Brief    : Lane identifiers, judge state encoding and key priority helper.
// Revision : 1.0
// ============================================================================
package tile_pkg;

  localparam logic [2:0] LINE_NONE = 3'd0;
  localparam logic [2:0] LINE_K3   = 3'd1;
  localparam logic [2:0] LINE_K2   = 3'd2;
  localparam logic [2:0] LINE_K1   = 3'd3;
  localparam logic [2:0] LINE_K0   = 3'd4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HIT     = 3'd1;
  localparam logic [2:0] ST_MISS    = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_FAILED  = 3'd4;

  // Bit 3 is key3; the highest-priority pressed key wins, the rest are dropped.
  function automatic logic [2:0] pick_lane(input logic [3:0] press);
    if (press[3])      return LINE_K3;
    else if (press[2]) return LINE_K2;
    else if (press[1]) return LINE_K1;
    else if (press[0]) return LINE_K0;
    else               return LINE_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : 2-flop sync, stability counter and press pulse for one
//            active-low key.
// Revision : 1.0
// ============================================================================
module key_debounce
  import tile_pkg::*;
#(
  parameter int DB_COUNT = 50000,
  parameter int DB_W     = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam logic [DB_W-1:0] C_LAST = DB_W'(DB_COUNT - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;

  // The counter only runs while the synchronized level disagrees with the
  // debounced level, so any bounce back restarts the stability window.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == C_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= level & ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_judge.sv
`default_nettype none
// ============================================================================
// Module   : key_judge
// Brief    : Judges debounced key presses against the bottom tile lane and
//            hands off to the hit or fail drawer; keeps score and game-over.
// Revision : 1.0
// ============================================================================
module key_judge
  import tile_pkg::*;
#(
  parameter int DB_COUNT = 50000,
  parameter int DB_W     = 16,
  parameter int SCORE_W  = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               key3,
  input  logic               key2,
  input  logic               key1,
  input  logic               key0,
  input  logic               judge_enable,
  input  logic [2:0]         target_line_id,
  output logic               correct_input_go,
  input  logic               correct_input_done,
  output logic               incorrect_input_go,
  input  logic               incorrect_input_done,
  output logic [2:0]         pressed_line_id,
  output logic [SCORE_W-1:0] score,
  output logic               fail
);

  logic [3:0] keys_n;
  logic [3:0] levels;
  logic [3:0] presses;
  logic [2:0] lane;
  logic [2:0] state;

  assign keys_n = {key3, key2, key1, key0};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_key
      key_debounce #(
        .DB_COUNT(DB_COUNT),
        .DB_W    (DB_W)
      ) u_debounce (
        .clock (clock),
        .resetn(resetn),
        .key_n (keys_n[i]),
        .level (levels[i]),
        .press (presses[i])
      );
    end
  endgenerate

  assign lane = pick_lane(presses);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      pressed_line_id <= LINE_NONE;
      score           <= '0;
      fail            <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (judge_enable && (presses != 4'b0000)) begin
            pressed_line_id <= lane;
            if ((target_line_id != LINE_NONE) && (lane == target_line_id))
              state <= ST_HIT;
            else
              state <= ST_MISS;
          end
        end
        ST_HIT: begin
          if (correct_input_done) begin
            if (score != {SCORE_W{1'b1}})
              score <= score + SCORE_W'(1);
            state <= ST_RELEASE;
          end
        end
        ST_MISS: begin
          if (incorrect_input_done) begin
            fail  <= 1'b1;
            state <= ST_FAILED;
          end
        end
        // Wait for every key to be released so a held key cannot re-trigger.
        ST_RELEASE: begin
          if (&levels)
            state <= ST_IDLE;
        end
        ST_FAILED: state <= ST_FAILED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign correct_input_go   = (state == ST_HIT);
  assign incorrect_input_go = (state == ST_MISS);

endmodule
`default_nettype wire

// File: tb/tb_key_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_judge
// Brief    : Directed self-checking bench for key_judge with DB_COUNT = 4.
// Revision : 1.0
// ============================================================================
module tb_key_judge;

  localparam int DB_COUNT = 4;
  localparam int DB_W     = 16;
  localparam int SCORE_W  = 8;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic               key3 = 1'b1;
  logic               key2 = 1'b1;
  logic               key1 = 1'b1;
  logic               key0 = 1'b1;
  logic               judge_enable = 1'b1;
  logic [2:0]         target_line_id = 3'd0;
  logic               correct_input_go;
  logic               correct_input_done = 1'b0;
  logic               incorrect_input_go;
  logic               incorrect_input_done = 1'b0;
  logic [2:0]         pressed_line_id;
  logic [SCORE_W-1:0] score;
  logic               fail;

  int checks = 0;
  int errors = 0;

  key_judge #(
    .DB_COUNT(DB_COUNT),
    .DB_W    (DB_W),
    .SCORE_W (SCORE_W)
  ) dut (
    .clock               (clock),
    .resetn              (resetn),
    .key3                (key3),
    .key2                (key2),
    .key1                (key1),
    .key0                (key0),
    .judge_enable        (judge_enable),
    .target_line_id      (target_line_id),
    .correct_input_go    (correct_input_go),
    .correct_input_done  (correct_input_done),
    .incorrect_input_go  (incorrect_input_go),
    .incorrect_input_done(incorrect_input_done),
    .pressed_line_id     (pressed_line_id),
    .score               (score),
    .fail                (fail)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One full hit on key3 (target must be 1): press, done, release.
  task automatic quick_hit();
    key3 = 1'b0;
    tick(7);
    correct_input_done = 1'b1;
    tick(1);
    correct_input_done = 1'b0;
    key3 = 1'b1;
    tick(8);
  endtask

  initial begin
    tick(3);
    check("rst_cgo",   int'(correct_input_go), 0);
    check("rst_igo",   int'(incorrect_input_go), 0);
    check("rst_line",  int'(pressed_line_id), 0);
    check("rst_score", int'(score), 0);
    check("rst_fail",  int'(fail), 0);
    resetn = 1'b1;
    tick(2);

    // Correct hit: go rises on the 7th edge after key2 falls.
    target_line_id = 3'd2;
    key2 = 1'b0;
    tick(6);
    check("hit_go_early", int'(correct_input_go), 0);
    tick(1);
    check("hit_go",   int'(correct_input_go), 1);
    check("hit_igo",  int'(incorrect_input_go), 0);
    check("hit_line", int'(pressed_line_id), 2);
    correct_input_done = 1'b1;
    tick(1);
    correct_input_done = 1'b0;
    check("hit_go_drop", int'(correct_input_go), 0);
    check("hit_score",   int'(score), 1);
    tick(3);
    check("hold_no_retrigger", int'(correct_input_go), 0);
    key2 = 1'b1;
    tick(10);
    check("line_held", int'(pressed_line_id), 2);

    // Second hit, with a stray fail-drawer done that must be ignored.
    key2 = 1'b0;
    tick(7);
    check("hit2_go", int'(correct_input_go), 1);
    incorrect_input_done = 1'b1;
    tick(1);
    incorrect_input_done = 1'b0;
    check("hit2_stray_done_go",   int'(correct_input_go), 1);
    check("hit2_stray_done_fail", int'(fail), 0);
    correct_input_done = 1'b1;
    tick(1);
    correct_input_done = 1'b0;
    check("hit2_score", int'(score), 2);
    key2 = 1'b1;
    tick(10);

    // Wrong key: key0 (lane 4) against target 1.
    target_line_id = 3'd1;
    key0 = 1'b0;
    tick(7);
    check("miss_igo",  int'(incorrect_input_go), 1);
    check("miss_cgo",  int'(correct_input_go), 0);
    check("miss_line", int'(pressed_line_id), 4);
    target_line_id = 3'd4;
    correct_input_done = 1'b1;
    tick(1);
    correct_input_done = 1'b0;
    check("miss_stray_done_igo", int'(incorrect_input_go), 1);
    check("miss_stray_score",    int'(score), 2);
    incorrect_input_done = 1'b1;
    tick(1);
    incorrect_input_done = 1'b0;
    check("miss_igo_drop", int'(incorrect_input_go), 0);
    check("miss_fail",     int'(fail), 1);
    key0 = 1'b1;
    tick(10);
    target_line_id = 3'd1;
    key3 = 1'b0;
    tick(8);
    check("failed_cgo", int'(correct_input_go), 0);
    check("failed_igo", int'(incorrect_input_go), 0);
    key3 = 1'b1;
    tick(10);
    check("failed_sticky", int'(fail), 1);
    resetn = 1'b0;
    tick(1);
    check("reset_fail",  int'(fail), 0);
    check("reset_score", int'(score), 0);
    resetn = 1'b1;
    tick(2);

    // Bounce: key1 low for 2 cycles at a time never survives 4 samples.
    target_line_id = 3'd3;
    for (int i = 0; i < 5; i++) begin
      key1 = 1'b0;
      tick(2);
      key1 = 1'b1;
      tick(2);
    end
    tick(10);
    check("bounce_cgo", int'(correct_input_go), 0);
    check("bounce_igo", int'(incorrect_input_go), 0);

    // Simultaneous key3 + key0: key3 wins.
    target_line_id = 3'd1;
    key3 = 1'b0;
    key0 = 1'b0;
    tick(7);
    check("simul_cgo",  int'(correct_input_go), 1);
    check("simul_igo",  int'(incorrect_input_go), 0);
    check("simul_line", int'(pressed_line_id), 1);
    correct_input_done = 1'b1;
    tick(1);
    correct_input_done = 1'b0;
    check("simul_score", int'(score), 1);
    key3 = 1'b1;
    key0 = 1'b1;
    tick(10);
    check("simul_no_k0_igo", int'(incorrect_input_go), 0);
    check("simul_no_k0_cgo", int'(correct_input_go), 0);

    // No tile present: any press is a miss.
    target_line_id = 3'd0;
    key2 = 1'b0;
    tick(7);
    check("none_igo",  int'(incorrect_input_go), 1);
    check("none_cgo",  int'(correct_input_go), 0);
    check("none_line", int'(pressed_line_id), 2);
    key2 = 1'b1;
    incorrect_input_done = 1'b1;
    tick(1);
    incorrect_input_done = 1'b0;
    check("none_fail", int'(fail), 1);
    tick(10);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(1);

    // Judging disabled: press is debounced but discarded.
    judge_enable = 1'b0;
    target_line_id = 3'd1;
    key3 = 1'b0;
    tick(8);
    check("dis_cgo",  int'(correct_input_go), 0);
    check("dis_igo",  int'(incorrect_input_go), 0);
    check("dis_line", int'(pressed_line_id), 0);
    key3 = 1'b1;
    tick(10);
    judge_enable = 1'b1;

    // Score saturation.
    for (int i = 0; i < 255; i++) quick_hit();
    check("sat_255", int'(score), 255);
    quick_hit();
    check("sat_hold", int'(score), 255);

    // Reset while correct_input_go is high.
    target_line_id = 3'd2;
    key2 = 1'b0;
    tick(7);
    check("mid_go", int'(correct_input_go), 1);
    resetn = 1'b0;
    key2 = 1'b1;
    tick(1);
    check("mid_rst_cgo",   int'(correct_input_go), 0);
    check("mid_rst_score", int'(score), 0);
    check("mid_rst_line",  int'(pressed_line_id), 0);
    resetn = 1'b1;
    correct_input_done = 1'b1;
    tick(2);
    correct_input_done = 1'b0;
    check("mid_late_done_cgo",   int'(correct_input_go), 0);
    check("mid_late_done_score", int'(score), 0);
    tick(8);
    key2 = 1'b0;
    tick(7);
    check("mid_idle_go",   int'(correct_input_go), 1);
    check("mid_idle_line", int'(pressed_line_id), 2);
    correct_input_done = 1'b1;
    tick(1);
    correct_input_done = 1'b0;
    check("mid_idle_score", int'(score), 1);
    key2 = 1'b1;
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_judge.md
# key_judge

Upstream input-judging stage for the tile game. Debounces the four active-low push keys, detects a new press, and compares the pressed lane against the lane of the bottom-most live tile. It then issues exactly one draw request per press, to either the correct-hit drawer or the wrong-key fail drawer (`incorrect_input_go` / `incorrect_input_done`), and waits for that drawer's done. It also keeps the score and latches game-over on a wrong key.

## Interface
- `DB_COUNT`, default 50000: number of consecutive stable synchronized samples before a key's debounced level changes.
- `DB_W`, default 16: counter width; must satisfy `DB_COUNT < 2**DB_W`.
- `SCORE_W`, default 8: score width.

- `clock` input 1: single system clock.
- `resetn` input 1: synchronous active-low reset.
- `key3`, `key2`, `key1`, `key0` input 1 each: raw keys, asynchronous, active-low (0 = pressed).
- `judge_enable` input 1: 1 = presses are judged; 0 = presses are debounced but discarded.
- `target_line_id` input 3: lane of the bottom tile, 1..4; 0 = no tile present.
- `correct_input_go` output 1: request to the hit drawer.
- `correct_input_done` input 1: 1-cycle or level done from the hit drawer.
- `incorrect_input_go` output 1: request to the fail drawer.
- `incorrect_input_done` input 1: done from the fail drawer.
- `pressed_line_id` output 3: lane of the judged press, held until the next judged press.
- `score` output SCORE_W: count of correct hits, saturating.
- `fail` output 1: game-over flag, sticky until reset.

## Operation
- **Sync:** each key passes through a 2-flop synchronizer.
- **Debounce:** a per-key counter resets whenever the synchronized level differs from the debounced level. When the counter reaches `DB_COUNT`, the debounced level takes the synchronized value. Debounced level resets to 1 (released).
- **Press event:** a registered debounced 1→0 transition, one cycle wide.
- **Lane mapping:** key3→1, key2→2, key1→3, key0→4.
- **Simultaneous press events:** priority is key3 > key2 > key1 > key0. Lower-priority presses in the same cycle are dropped.
- **FSM states:** IDLE, HIT, MISS, RELEASE, FAILED.
  - IDLE: on a press event with `judge_enable`=1, latch `pressed_line_id`.
    - If the lane equals `target_line_id` and `target_line_id`≠0, go to HIT.
    - Otherwise go to MISS, including the case `target_line_id`=0.
  - HIT: `correct_input_go`=1. On `correct_input_done`=1, increment `score` (saturating at all-ones) and go to RELEASE.
  - MISS: `incorrect_input_go`=1. On `incorrect_input_done`=1, set `fail` and go to FAILED.
  - RELEASE: wait until all four debounced levels are 1, then go to IDLE. Presses seen in this state are discarded.
  - FAILED: terminal. Both go outputs are 0 and all presses are ignored until `resetn`=0.
- Press events arriving in HIT or MISS are discarded.
- Both go outputs are never high together.
- **Reset values:** state IDLE, both go 0, `pressed_line_id` 0, `score` 0, `fail` 0, debounced levels 1, debounce counters 0, synchronizers 1.

## Timing
- Raw key change → debounced change: 2 synchronizer cycles + `DB_COUNT` stable cycles.
- Press event registered at cycle t in IDLE → go high at t+1. `pressed_line_id` is valid at t+1.
- Go is held high while the matching done is low. Done sampled high at cycle d → go low at d+1, and:
  - `score` updates at d+1, or
  - `fail` rises at d+1.
- Done asserted in the same cycle go first rises is accepted; minimum go width is 1 cycle.
- A done input that is not matched to the active go is ignored.
- `resetn`=0 sampled at any cycle → all outputs at reset values on the next edge, including mid-handshake with go high.
- `target_line_id` is sampled only in the press-event cycle. Later changes do not alter the verdict.

## Structure
- Shared package `tile_pkg` holds:
  - constants `LINE_NONE`=3'd0, `LINE_K3`=3'd1, `LINE_K2`=3'd2, `LINE_K1`=3'd3, `LINE_K0`=3'd4;
  - the judge state encoding.
- One sub-module, `key_debounce`: synchronizer, counter, debounced level and press pulse for one key. It is instantiated four times.
- The judge FSM and score stay in `key_judge`.

## Test plan
All scenarios run with `DB_COUNT`=4.
- **Correct hit:** `target_line_id`=2, key2 held low 10 cycles → `correct_input_go` high 7 cycles after the key falls, `pressed_line_id`=2. Done pulse → go low next cycle, `score`=1. Re-press is ignored until key2 is released.
- **Wrong key:** `target_line_id`=1, key0 press → `incorrect_input_go`=1, `pressed_line_id`=4. Done → `fail`=1. A further press gives no go; `resetn` pulse clears `fail`.
- **Bounce:** key1 toggles every 2 cycles for 20 cycles, then stays high → no press event, no go.
- **Simultaneous press:** key3 and key0 fall in the same cycle, `target_line_id`=1 → HIT with `pressed_line_id`=1; key0 is not judged.
- **Edge cases:**
  - `target_line_id`=0 with a press → MISS.
  - `judge_enable`=0 with a press → nothing happens.
  - `score` preloaded to 255 via repeated hits, then one more hit → stays 255.
- **Reset mid-handshake:** `resetn` low while `correct_input_go`=1 → go 0, `score` 0, state IDLE on the next edge; done arriving afterwards is ignored.
